// File: rtl/expr_checker_if.sv
// expr_checker_if
//   Bundles the character stream and the recogniser status for expr_checker.
//
//   Handshake: in_valid alone qualifies in. The checker has no back-pressure and
//   consumes in on every rising edge where in_valid=1. When in_valid=0, nothing
//   in the checker changes.
//
//   Signals
//     in         8      ASCII character           (master -> slave)
//     in_valid   1      consume in this cycle     (master -> slave)
//     out        1      complete, balanced expr   (slave -> master)
//     err        1      sticky illegal-char flag  (slave -> master)
//     depth      DW     unclosed '(' count        (slave -> master)
//     len        LEN_W  saturating char count     (slave -> master)
//     state_dbg  2      FSM state for observation (slave -> master)
interface expr_checker_if #(
    parameter int MAX_DEPTH = 4,
    parameter int LEN_W     = 8
);
    localparam int DW = $clog2(MAX_DEPTH + 1);

    logic [7:0]       in;
    logic             in_valid;
    logic             out;
    logic             err;
    logic [DW-1:0]    depth;
    logic [LEN_W-1:0] len;
    logic [1:0]       state_dbg;

    modport master (
        output in, in_valid,
        input  out, err, depth, len, state_dbg
    );

    modport slave (
        input  in, in_valid,
        output out, err, depth, len, state_dbg
    );
endinterface

// File: rtl/expr_checker.sv
// expr_checker
//   Streaming recogniser for arithmetic expressions, one ASCII char per valid cycle.
//   Grammar: expr := term (op term)* ; term := num | '(' expr ')'.
//
//   Ports
//     clk   rising-edge clock
//     clr   synchronous active-high reset; wins over in_valid
//     bus   expr_checker_if slave: in/in_valid in, out/err/depth/len/state_dbg out
//
//   All outputs are decoded from registers, so a char consumed at edge N
//   appears on the outputs after edge N.
module expr_checker #(
    parameter int MAX_DEPTH     = 4,
    parameter int MULTI_DIGIT   = 0,
    parameter int ALLOW_SUB_DIV = 0,
    parameter int LEN_W         = 8
) (
    input logic          clk,
    input logic          clr,
    expr_checker_if.slave bus
);
    localparam int DW = $clog2(MAX_DEPTH + 1);
    localparam logic [DW-1:0] MAX_D = DW'(MAX_DEPTH);

    typedef enum logic [1:0] {
        EXP_TERM = 2'd0,
        IN_NUM   = 2'd1,
        AFTER_CL = 2'd2,
        ERR      = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic [LEN_W-1:0] len_q;

    logic is_digit, is_op, is_open, is_close;

    always_comb begin
        is_digit = (bus.in >= "0") && (bus.in <= "9");
        is_open  = (bus.in == "(");
        is_close = (bus.in == ")");
        is_op    = (bus.in == "+") || (bus.in == "*") ||
                   ((ALLOW_SUB_DIV != 0) && ((bus.in == "-") || (bus.in == "/")));
    end

    // Next-state logic. Any char not listed for a state drops into ERR; depth
    // is only touched on a legal bracket, so it freezes when ERR is entered.
    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        if (bus.in_valid) begin
            case (state_q)
                EXP_TERM: begin
                    if (is_digit) begin
                        state_d = IN_NUM;
                    end else if (is_open && (depth_q < MAX_D)) begin
                        depth_d = depth_q + DW'(1);
                    end else begin
                        state_d = ERR;
                    end
                end
                IN_NUM: begin
                    if (is_digit) begin
                        state_d = (MULTI_DIGIT != 0) ? IN_NUM : ERR;
                    end else if (is_op) begin
                        state_d = EXP_TERM;
                    end else if (is_close && (depth_q != '0)) begin
                        depth_d = depth_q - DW'(1);
                        state_d = AFTER_CL;
                    end else begin
                        state_d = ERR;
                    end
                end
                AFTER_CL: begin
                    if (is_op) begin
                        state_d = EXP_TERM;
                    end else if (is_close && (depth_q != '0)) begin
                        depth_d = depth_q - DW'(1);
                    end else begin
                        state_d = ERR;
                    end
                end
                default: state_d = ERR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= EXP_TERM;
            depth_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            // Count every consumed char, errors included, saturating at all-ones.
            if (bus.in_valid && (len_q != '1)) begin
                len_q <= len_q + LEN_W'(1);
            end
        end
    end

    assign bus.err       = (state_q == ERR);
    assign bus.out       = ((state_q == IN_NUM) || (state_q == AFTER_CL)) &&
                           (depth_q == '0) && (state_q != ERR);
    assign bus.depth     = depth_q;
    assign bus.len       = len_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_expr_checker.sv
// tb_expr_checker
//   Drives one character stream into two differently configured checkers:
//     dut_a: MAX_DEPTH=4, MULTI_DIGIT=0, ALLOW_SUB_DIV=0, LEN_W=8
//     dut_b: MAX_DEPTH=2, MULTI_DIGIT=1, ALLOW_SUB_DIV=1, LEN_W=2
//   The reference model keeps the chars accepted since clr and re-judges the
//   whole history from the previous-char rules of the grammar.
module tb_expr_checker;
    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] in_ch = 8'h00;
    logic       in_vld = 1'b0;

    always #5 clk = ~clk;

    expr_checker_if #(.MAX_DEPTH(4), .LEN_W(8)) bus_a ();
    expr_checker_if #(.MAX_DEPTH(2), .LEN_W(2)) bus_b ();

    assign bus_a.in       = in_ch;
    assign bus_a.in_valid = in_vld;
    assign bus_b.in       = in_ch;
    assign bus_b.in_valid = in_vld;

    expr_checker #(.MAX_DEPTH(4), .MULTI_DIGIT(0), .ALLOW_SUB_DIV(0), .LEN_W(8)) dut_a (
        .clk(clk), .clr(clr), .bus(bus_a)
    );
    expr_checker #(.MAX_DEPTH(2), .MULTI_DIGIT(1), .ALLOW_SUB_DIV(1), .LEN_W(2)) dut_b (
        .clk(clk), .clr(clr), .bus(bus_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // chars consumed since the last clr
    logic [7:0] hist[$];

    // ---------------- reference model ----------------
    localparam int P_NONE = 0, P_DIG = 1, P_OP = 2, P_OPEN = 3, P_CLOSE = 4;

    function automatic void model(input int maxd, input bit md, input bit asd,
                                  output bit o, output bit e, output int d);
        int prev = P_NONE;
        e = 1'b0;
        d = 0;
        foreach (hist[i]) begin
            logic [7:0] c = hist[i];
            bit ok;
            int cls;
            bit after_term = (prev == P_DIG) || (prev == P_CLOSE);
            bit want_term  = (prev == P_NONE) || (prev == P_OP) || (prev == P_OPEN);
            if (c >= "0" && c <= "9") begin
                cls = P_DIG;
                ok  = want_term || (prev == P_DIG && md);
            end else if (c == "(") begin
                cls = P_OPEN;
                ok  = want_term && (d < maxd);
                if (ok) d++;
            end else if (c == ")") begin
                cls = P_CLOSE;
                ok  = after_term && (d > 0);
                if (ok) d--;
            end else if (c == "+" || c == "*" || (asd && (c == "-" || c == "/"))) begin
                cls = P_OP;
                ok  = after_term;
            end else begin
                cls = P_NONE;
                ok  = 1'b0;
            end
            if (!ok) begin
                e = 1'b1;
                break;
            end
            prev = cls;
        end
        o = !e && ((prev == P_DIG) || (prev == P_CLOSE)) && (d == 0);
    endfunction

    function automatic int sat_len(input int lw);
        int mx = (1 << lw) - 1;
        return (hist.size() > mx) ? mx : hist.size();
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic step(input bit c, input bit v, input logic [7:0] ch);
        clr    = c;
        in_vld = v;
        in_ch  = ch;
        @(posedge clk);
        if (c) hist.delete();
        else if (v) hist.push_back(ch);
        #1;
        clr    = 1'b0;
        in_vld = 1'b0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        bit o, e;
        int d;
        model(4, 1'b0, 1'b0, o, e, d);
        check({tag, " a.out"},   int'(bus_a.out),   int'(o));
        check({tag, " a.err"},   int'(bus_a.err),   int'(e));
        check({tag, " a.depth"}, int'(bus_a.depth), d);
        check({tag, " a.len"},   int'(bus_a.len),   sat_len(8));
        model(2, 1'b1, 1'b1, o, e, d);
        check({tag, " b.out"},   int'(bus_b.out),   int'(o));
        check({tag, " b.err"},   int'(bus_b.err),   int'(e));
        check({tag, " b.depth"}, int'(bus_b.depth), d);
        check({tag, " b.len"},   int'(bus_b.len),   sat_len(2));
    endtask

    task automatic send_str(input string s, input bit bubbles);
        for (int i = 0; i < s.len(); i++) begin
            if (bubbles) begin
                step(1'b0, 1'b0, 8'h00);
                check_model("bubble");
            end
            step(1'b0, 1'b1, s[i]);
            check_model("send");
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit         clr_first;
        logic [7:0] ch;
        bit         oa, ea;
        int         da, la;
        bit         ob, eb;
        int         db, lb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit c, input logic [7:0] ch,
                       input bit oa, input bit ea, input int da, input int la,
                       input bit ob, input bit eb, input int db, input int lb);
        vec_t v;
        v = '{c, ch, oa, ea, da, la, ob, eb, db, lb};
        vecs.push_back(v);
    endtask

    string alpha = "0123456789((()))+*-/+*x 0";

    initial begin
        // "1+2"
        add(1, "1", 1,0,0,1, 1,0,0,1);
        add(0, "+", 0,0,0,2, 0,0,0,2);
        add(0, "2", 1,0,0,3, 1,0,0,3);
        // "(1+2)*3"
        add(1, "(", 0,0,1,1, 0,0,1,1);
        add(0, "1", 0,0,1,2, 0,0,1,2);
        add(0, "+", 0,0,1,3, 0,0,1,3);
        add(0, "2", 0,0,1,4, 0,0,1,3);
        add(0, ")", 1,0,0,5, 1,0,0,3);
        add(0, "*", 0,0,0,6, 0,0,0,3);
        add(0, "3", 1,0,0,7, 1,0,0,3);
        // "12"
        add(1, "1", 1,0,0,1, 1,0,0,1);
        add(0, "2", 0,1,0,2, 1,0,0,2);
        // "((1))"
        add(1, "(", 0,0,1,1, 0,0,1,1);
        add(0, "(", 0,0,2,2, 0,0,2,2);
        add(0, "1", 0,0,2,3, 0,0,2,3);
        add(0, ")", 0,0,1,4, 0,0,1,3);
        add(0, ")", 1,0,0,5, 1,0,0,3);
        // "(((" : overflow only for MAX_DEPTH=2
        add(1, "(", 0,0,1,1, 0,0,1,1);
        add(0, "(", 0,0,2,2, 0,0,2,2);
        add(0, "(", 0,0,3,3, 0,1,2,3);
        // ")" underflow
        add(1, ")", 0,1,0,1, 0,1,0,1);
        // "1-2"
        add(1, "1", 1,0,0,1, 1,0,0,1);
        add(0, "-", 0,1,0,2, 0,0,0,2);
        add(0, "2", 0,1,0,3, 1,0,0,3);
        // "(1)(" : '(' after ')' is illegal
        add(1, "(", 0,0,1,1, 0,0,1,1);
        add(0, "1", 0,0,1,2, 0,0,1,2);
        add(0, ")", 1,0,0,3, 1,0,0,3);
        add(0, "(", 0,1,0,4, 0,1,0,3);

        // reset state
        step(1'b1, 1'b0, 8'h00);
        check("rst a.out", int'(bus_a.out), 0);
        check("rst a.err", int'(bus_a.err), 0);
        check("rst a.depth", int'(bus_a.depth), 0);
        check("rst a.len", int'(bus_a.len), 0);
        check("rst b.out", int'(bus_b.out), 0);
        check("rst b.len", int'(bus_b.len), 0);

        // table-driven vectors
        foreach (vecs[i]) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            if (vecs[i].clr_first) step(1'b1, 1'b0, 8'h00);
            step(1'b0, 1'b1, vecs[i].ch);
            check({nm, " a.out"},   int'(bus_a.out),   int'(vecs[i].oa));
            check({nm, " a.err"},   int'(bus_a.err),   int'(vecs[i].ea));
            check({nm, " a.depth"}, int'(bus_a.depth), vecs[i].da);
            check({nm, " a.len"},   int'(bus_a.len),   vecs[i].la);
            check({nm, " b.out"},   int'(bus_b.out),   int'(vecs[i].ob));
            check({nm, " b.err"},   int'(bus_b.err),   int'(vecs[i].eb));
            check({nm, " b.depth"}, int'(bus_b.depth), vecs[i].db);
            check({nm, " b.len"},   int'(bus_b.len),   vecs[i].lb);
            check_model(nm);
        end

        // "(1+" with bubbles, then clr mid-stream with in_valid high
        step(1'b1, 1'b0, 8'h00);
        send_str("(1+", 1'b1);
        check("bub a.depth", int'(bus_a.depth), 1);
        check("bub a.len", int'(bus_a.len), 3);
        check("bub a.out", int'(bus_a.out), 0);
        check("bub a.err", int'(bus_a.err), 0);
        step(1'b1, 1'b1, "7");
        check("clr a.depth", int'(bus_a.depth), 0);
        check("clr a.len", int'(bus_a.len), 0);
        check("clr b.len", int'(bus_b.len), 0);
        check("clr a.out", int'(bus_a.out), 0);
        step(1'b0, 1'b1, "5");
        check("5 a.out", int'(bus_a.out), 1);
        check("5 a.len", int'(bus_a.len), 1);
        check("5 b.out", int'(bus_b.out), 1);
        // five digits: multi-digit number in b, len sticks at 3
        step(1'b1, 1'b0, 8'h00);
        send_str("12345", 1'b0);
        check("5dig b.len", int'(bus_b.len), 3);
        check("5dig b.out", int'(bus_b.out), 1);
        check("5dig a.err", int'(bus_a.err), 1);
        check("5dig a.len", int'(bus_a.len), 5);

        // long error stream: 8-bit len saturates at 255
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 260; i++) step(1'b0, 1'b1, "+");
        check("sat a.len", int'(bus_a.len), 255);
        check("sat a.err", int'(bus_a.err), 1);
        check("sat b.len", int'(bus_b.len), 3);
        check_model("sat");

        // randomized segments against the model
        for (int seg = 0; seg < 80; seg++) begin
            int n;
            step(1'b1, 1'b0, 8'h00);
            check_model("rnd clr");
            n = $urandom_range(1, 30);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
                    check_model("rnd bubble");
                end
                step(1'b0, 1'b1, alpha[$urandom_range(0, alpha.len() - 1)]);
                check_model("rnd");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
